// File: rtl/bsg_fma_pkg.sv
// bsg_fma_pkg: shared types and constants for the FMA auxiliary cross-term adder.
package bsg_fma_pkg;
    localparam int pipe_depth_lp = 2;
    localparam int pp_max_width_lp = 64;
    typedef logic [pp_max_width_lp-1:0] pp_row_t;
    // One partial-product row: the extended operand shifted into place when its multiplier bit is set.
    function automatic pp_row_t pp_row(input pp_row_t op_x, input logic en, input int sh);
        return en ? (op_x << sh) : '0;
    endfunction
endpackage

// File: rtl/bsg_adder_wallace_tree.sv
// bsg_adder_wallace_tree: carry-save reduction of iter_step_p rows into two vectors whose sum is the row sum mod 2^width_p.
module bsg_adder_wallace_tree #(
    parameter int width_p = 8,
    parameter int iter_step_p = 16
) (
    input  logic [iter_step_p-1:0][width_p-1:0] ops_i,
    output logic [width_p-1:0]                  resA_o,
    output logic [width_p-1:0]                  resB_o
);
    always_comb begin
        logic [width_p-1:0] s;
        logic [width_p-1:0] c;
        s = '0;
        c = '0;
        for (int i = 0; i < iter_step_p; i++) begin
            {s, c} = {s ^ c ^ ops_i[i], ((s & c) | (s & ops_i[i]) | (c & ops_i[i])) << 1};
        end
        resA_o = s;
        resB_o = c;
    end
endmodule

// File: rtl/bsg_fma_aux_adder_stage.sv
// bsg_fma_aux_adder_stage: one valid/ready pipeline register; loads when empty or when its output is taken.
module bsg_fma_aux_adder_stage #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    assign ready_o = ~v_o | yumi_i;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_o    <= 1'b0;
            data_o <= '0;
        end else if (ready_o) begin
            v_o <= v_i;
            if (v_i) data_o <= data_i;
        end
    end
endmodule

// File: rtl/bsg_fma_aux_adder_pipe.sv
// bsg_fma_aux_adder_pipe: two-stage pipelined (a_h*b_l + a_l*b_h) mod 2^out_width_p with tag passthrough.
module bsg_fma_aux_adder_pipe
    import bsg_fma_pkg::*;
#(
    parameter int e_p = 8,
    parameter int out_width_p = 8,
    parameter int tag_width_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    output logic                   ready_o,
    input  logic [e_p-1:0]         a_l_i,
    input  logic [e_p-1:0]         a_h_i,
    input  logic                   a_signed_i,
    input  logic [e_p-1:0]         b_l_i,
    input  logic [e_p-1:0]         b_h_i,
    input  logic                   b_signed_i,
    input  logic [tag_width_p-1:0] tag_i,
    output logic                   v_o,
    input  logic                   yumi_i,
    output logic [out_width_p-1:0] mod_o,
    output logic [tag_width_p-1:0] tag_o
);
    localparam int s1_w_lp = 2*out_width_p + tag_width_p;
    localparam int s2_w_lp = out_width_p + tag_width_p;
    pp_row_t a_h_x, b_h_x;
    logic [2*e_p-1:0][out_width_p-1:0] rows;
    logic [out_width_p-1:0] csa_a, csa_b, s1_a, s1_b;
    logic [tag_width_p-1:0] s1_tag;
    logic [s1_w_lp-1:0] s1_data;
    logic s1_v, s2_ready;
    // High halves carry an extra sign bit that is only set for signed negative operands.
    assign a_h_x = pp_row_t'(signed'({a_signed_i & a_h_i[e_p-1], a_h_i}));
    assign b_h_x = pp_row_t'(signed'({b_signed_i & b_h_i[e_p-1], b_h_i}));
    always_comb begin
        rows = '0;
        for (int i = 0; i < e_p; i++) begin
            rows[i]     = out_width_p'(pp_row(a_h_x, b_l_i[i], i));
            rows[e_p+i] = out_width_p'(pp_row(b_h_x, a_l_i[i], i));
        end
    end
    bsg_adder_wallace_tree #(.width_p(out_width_p), .iter_step_p(2*e_p)) wt (
        .ops_i (rows),
        .resA_o(csa_a),
        .resB_o(csa_b)
    );
    bsg_fma_aux_adder_stage #(.width_p(s1_w_lp)) s1 (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .v_i    (v_i),
        .ready_o(ready_o),
        .data_i ({csa_a, csa_b, tag_i}),
        .v_o    (s1_v),
        .data_o (s1_data),
        .yumi_i (s1_v & s2_ready)
    );
    assign {s1_a, s1_b, s1_tag} = s1_data;
    bsg_fma_aux_adder_stage #(.width_p(s2_w_lp)) s2 (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .v_i    (s1_v),
        .ready_o(s2_ready),
        .data_i ({s1_a + s1_b, s1_tag}),
        .v_o    (v_o),
        .data_o ({mod_o, tag_o}),
        .yumi_i (yumi_i)
    );
endmodule

// File: tb/tb_bsg_fma_aux_adder_pipe.sv
// tb_bsg_fma_aux_adder_pipe: scoreboard bench driving 8- and 16-bit result instances with shared stimulus.
module tb_bsg_fma_aux_adder_pipe;
    import bsg_fma_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v_i = 1'b0, as = 1'b0, bs = 1'b0, yumi_en = 1'b0;
    logic [7:0] a_l = '0, a_h = '0, b_l = '0, b_h = '0;
    logic [3:0] tag = '0;
    logic [7:0] exp8_d = '0;
    logic [15:0] exp16_d = '0;
    logic rdy8, v8, y8, rdy16, v16, y16;
    logic [7:0] mod8;
    logic [15:0] mod16;
    logic [3:0] tag8, tag16;
    logic [11:0] q8[$];
    logic [19:0] q16[$];
    int checks = 0, errors = 0, pops8 = 0, pops16 = 0;
    always #5 clk = ~clk;
    assign y8 = yumi_en & v8;
    assign y16 = yumi_en & v16;
    bsg_fma_aux_adder_pipe #(.e_p(8), .out_width_p(8), .tag_width_p(4)) dut8 (
        .clk_i(clk), .reset_i(rst), .v_i(v_i), .ready_o(rdy8),
        .a_l_i(a_l), .a_h_i(a_h), .a_signed_i(as), .b_l_i(b_l), .b_h_i(b_h), .b_signed_i(bs),
        .tag_i(tag), .v_o(v8), .yumi_i(y8), .mod_o(mod8), .tag_o(tag8)
    );
    bsg_fma_aux_adder_pipe #(.e_p(8), .out_width_p(16), .tag_width_p(4)) dut16 (
        .clk_i(clk), .reset_i(rst), .v_i(v_i), .ready_o(rdy16),
        .a_l_i(a_l), .a_h_i(a_h), .a_signed_i(as), .b_l_i(b_l), .b_h_i(b_h), .b_signed_i(bs),
        .tag_i(tag), .v_o(v16), .yumi_i(y16), .mod_o(mod16), .tag_o(tag16)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [15:0] ref_mod(input logic [7:0] ah, al, bh, bl, input logic sa, sb);
        logic [31:0] ahx, bhx;
        ahx = sa ? {{24{ah[7]}}, ah} : {24'd0, ah};
        bhx = sb ? {{24{bh[7]}}, bh} : {24'd0, bh};
        return 16'(ahx * {24'd0, bl} + {24'd0, al} * bhx);
    endfunction
    task automatic send(input logic [7:0] ah, al, bh, bl, input logic sa, sb,
                        input logic [3:0] t, input logic [7:0] e8, input logic [15:0] e16);
        @(posedge clk); #1;
        v_i = 1'b1; a_h = ah; a_l = al; b_h = bh; b_l = bl; as = sa; bs = sb; tag = t;
        exp8_d = e8; exp16_d = e16;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            v_i = 1'b0;
        end
    endtask
    // Monitor: pop-and-compare on each handshake, then record newly accepted operations.
    always @(negedge clk) begin
        if (!rst) begin
            if (v8 && y8) begin
                if (q8.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out8_unexpected: got mod %0h tag %0h, no result expected", mod8, tag8);
                end else begin
                    chk("out8", {20'd0, mod8, tag8}, {20'd0, q8.pop_front()});
                    pops8++;
                end
            end
            if (v16 && y16) begin
                if (q16.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out16_unexpected: got mod %0h tag %0h, no result expected", mod16, tag16);
                end else begin
                    chk("out16", {12'd0, mod16, tag16}, {12'd0, q16.pop_front()});
                    pops16++;
                end
            end
            if (v_i && rdy8) q8.push_back({exp8_d, tag});
            if (v_i && rdy16) q16.push_back({exp16_d, tag});
        end
    end
    always @(negedge clk) begin
        if (!rst && ((y8 && !v8) || (y16 && !v16))) begin
            checks++; errors++;
            $display("FAIL yumi_without_valid: got yumi while v_o=0, required never");
        end
    end
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish within 200000");
        $fatal(1, "timeout");
    end
    initial begin
        int start8, start16;
        logic [7:0] rah, ral, rbh, rbl;
        logic [15:0] r;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_v8", {31'd0, v8}, 0);
        chk("reset_mod8", {24'd0, mod8}, 0);
        chk("reset_tag8", {28'd0, tag8}, 0);
        chk("reset_ready8", {31'd0, rdy8}, 1);
        chk("reset_v16", {31'd0, v16}, 0);
        chk("reset_mod16", {16'd0, mod16}, 0);
        chk("reset_ready16", {31'd0, rdy16}, 1);
        // Basic op and exact two-cycle latency.
        yumi_en = 1'b1;
        send(8'h03, 8'h05, 8'h02, 8'h04, 0, 0, 4'd1, 8'h16, 16'h0016);
        @(posedge clk); #1 v_i = 1'b0;
        for (int i = 1; i <= pipe_depth_lp; i++) begin
            @(negedge clk);
            chk($sformatf("latency_v8_c%0d", i), {31'd0, v8}, (i == pipe_depth_lp) ? 1 : 0);
            chk($sformatf("latency_v16_c%0d", i), {31'd0, v16}, (i == pipe_depth_lp) ? 1 : 0);
        end
        idle(2);
        // Wrap and signedness.
        send(8'hFF, 8'h00, 8'h00, 8'hFF, 0, 0, 4'd2, 8'h01, 16'hFE01);
        send(8'hFF, 8'h00, 8'h00, 8'hFF, 1, 0, 4'd3, 8'h01, 16'hFF01);
        send(8'hFF, 8'h00, 8'h00, 8'hFF, 0, 1, 4'd4, 8'h01, 16'hFE01);
        send(8'hFF, 8'h01, 8'h00, 8'h02, 1, 0, 4'd5, 8'hFE, 16'hFFFE);
        send(8'hFF, 8'h01, 8'h00, 8'h02, 0, 0, 4'd6, 8'hFE, 16'h01FE);
        idle(4);
        // Back-pressure: two accepted, third stalls, then drain with no bubble.
        yumi_en = 1'b0;
        send(8'h01, 8'h00, 8'h00, 8'h01, 0, 0, 4'd1, 8'h01, 16'h0001);
        send(8'h02, 8'h00, 8'h00, 8'h01, 0, 0, 4'd2, 8'h02, 16'h0002);
        send(8'h03, 8'h00, 8'h00, 8'h01, 0, 0, 4'd3, 8'h03, 16'h0003);
        @(negedge clk);
        chk("full_ready8", {31'd0, rdy8}, 0);
        chk("full_ready16", {31'd0, rdy16}, 0);
        chk("full_tag8_held", {28'd0, tag8}, 1);
        @(posedge clk); #1 yumi_en = 1'b1;
        @(negedge clk);
        chk("drain_ready8", {31'd0, rdy8}, 1);
        chk("drain_v8_c0", {31'd0, v8}, 1);
        @(posedge clk); #1 v_i = 1'b0;
        @(negedge clk);
        chk("drain_v8_c1", {31'd0, v8}, 1);
        chk("drain_v16_c1", {31'd0, v16}, 1);
        @(negedge clk);
        chk("drain_v8_c2", {31'd0, v8}, 1);
        idle(3);
        // Streaming at full rate against the reference model.
        start8 = pops8;
        start16 = pops16;
        for (int i = 0; i < 16; i++) begin
            rah = 8'($urandom); ral = 8'($urandom); rbh = 8'($urandom); rbl = 8'($urandom);
            r = ref_mod(rah, ral, rbh, rbl, i[0], i[1]);
            send(rah, ral, rbh, rbl, i[0], i[1], i[3:0], r[7:0], r);
        end
        @(posedge clk); #1 v_i = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("stream_count8", pops8 - start8, 16);
        chk("stream_count16", pops16 - start16, 16);
        idle(3);
        // Reset with two operations in flight.
        yumi_en = 1'b0;
        send(8'h07, 8'h00, 8'h00, 8'h01, 0, 0, 4'd7, 8'h07, 16'h0007);
        send(8'h08, 8'h00, 8'h00, 8'h01, 0, 0, 4'd8, 8'h08, 16'h0008);
        @(posedge clk); #1;
        v_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        q8.delete();
        q16.delete();
        chk("midreset_v8", {31'd0, v8}, 0);
        chk("midreset_mod8", {24'd0, mod8}, 0);
        chk("midreset_tag8", {28'd0, tag8}, 0);
        chk("midreset_v16", {31'd0, v16}, 0);
        chk("midreset_mod16", {16'd0, mod16}, 0);
        rst = 1'b0;
        yumi_en = 1'b1;
        idle(6);
        @(negedge clk);
        chk("post_reset_v8", {31'd0, v8}, 0);
        chk("post_reset_v16", {31'd0, v16}, 0);
        chk("q8_empty", q8.size(), 0);
        chk("q16_empty", q16.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
